// File: rtl/fpnew_issue_rob.sv
// In-order issue / reorder front-end for the FPU valid/ready interface.
// Optional sticky fflags accumulator: define FPNEW_ISSUE_ROB_FFLAGS_EN.

module fpnew_issue_rob_entry #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             set,
  input  logic             wr,
  input  logic             free,
  input  logic [WIDTH-1:0] wr_result,
  input  logic [4:0]       wr_status,
  output logic             alloc,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       status
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc <= 1'b0;
      done  <= 1'b0;
    end else if (flush) begin
      alloc <= 1'b0;
      done  <= 1'b0;
    end else begin
      // set/free never target the same entry: issue is blocked when full
      if (set)  begin alloc <= 1'b1; done <= 1'b0; end
      if (free) alloc <= 1'b0;
      if (wr)   done  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      result <= wr_result;
      status <= wr_status;
    end
  end

endmodule

module fpnew_issue_rob #(
  parameter int WIDTH = 64,
  parameter int OP_W  = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [3*WIDTH-1:0]   req_operands_i,
  input  logic [OP_W-1:0]      req_op_i,
  output logic                 fpu_in_valid_o,
  input  logic                 fpu_in_ready_i,
  output logic [3*WIDTH-1:0]   fpu_operands_o,
  output logic [OP_W-1:0]      fpu_op_o,
  output logic [TAG_W-1:0]     fpu_tag_o,
  input  logic                 fpu_out_valid_i,
  output logic                 fpu_out_ready_o,
  input  logic [WIDTH-1:0]     fpu_result_i,
  input  logic [4:0]           fpu_status_i,
  input  logic [TAG_W-1:0]     fpu_tag_i,
  output logic                 fpu_flush_o,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [WIDTH-1:0]     rsp_result_o,
  output logic [4:0]           rsp_status_o,
  input  logic                 flush_i,
  output logic [4:0]           fflags_o,
  input  logic                 fflags_clr_i,
  output logic [TAG_W:0]       count_o,
  output logic                 busy_o,
  output logic                 protocol_err_o
);

  logic [TAG_W:0]   head, tail;
  logic [TAG_W-1:0] head_idx, tail_idx;
  logic             empty, full;
  logic             issue_fire, resp_fire, slot_ok, wr_en, retire_fire;

  logic [DEPTH-1:0]            alloc_v, done_v;
  logic [DEPTH-1:0][WIDTH-1:0] ent_result;
  logic [DEPTH-1:0][4:0]       ent_status;

  assign head_idx = head[TAG_W-1:0];
  assign tail_idx = tail[TAG_W-1:0];
  assign empty    = (head == tail);
  assign full     = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);

  // Issue path is pure pass-through; valid must not look at the FPU's ready.
  assign fpu_in_valid_o = req_valid_i & ~full & ~flush_i;
  assign req_ready_o    = fpu_in_ready_i & ~full & ~flush_i;
  assign fpu_operands_o = req_operands_i;
  assign fpu_op_o       = req_op_i;
  assign fpu_tag_o      = tail_idx;
  assign issue_fire     = fpu_in_valid_o & fpu_in_ready_i;

  assign fpu_out_ready_o = ~flush_i;
  assign resp_fire       = fpu_out_valid_i & fpu_out_ready_o;
  assign slot_ok         = alloc_v[fpu_tag_i] & ~done_v[fpu_tag_i];
  assign wr_en           = resp_fire & slot_ok;

  assign rsp_valid_o  = ~empty & done_v[head_idx] & ~flush_i;
  assign rsp_result_o = ent_result[head_idx];
  assign rsp_status_o = ent_status[head_idx];
  assign retire_fire  = rsp_valid_o & rsp_ready_i;

  assign fpu_flush_o = flush_i;
  assign count_o     = tail - head;
  assign busy_o      = (count_o != '0);

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    fpnew_issue_rob_entry #(.WIDTH(WIDTH)) u_ent (
      .clk       (clk_i),
      .rst       (rst_i),
      .flush     (flush_i),
      .set       (issue_fire & (tail_idx == TAG_W'(e))),
      .wr        (wr_en & (fpu_tag_i == TAG_W'(e))),
      .free      (retire_fire & (head_idx == TAG_W'(e))),
      .wr_result (fpu_result_i),
      .wr_status (fpu_status_i),
      .alloc     (alloc_v[e]),
      .done      (done_v[e]),
      .result    (ent_result[e]),
      .status    (ent_status[e])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head <= '0;
      tail <= '0;
    end else if (flush_i) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (issue_fire)  tail <= tail + 1'b1;
      if (retire_fire) head <= head + 1'b1;
    end
  end

  // Stray response: target entry unallocated or already holding a result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                      protocol_err_o <= 1'b0;
    else if (resp_fire && !slot_ok) protocol_err_o <= 1'b1;
  end

`ifdef FPNEW_ISSUE_ROB_FFLAGS_EN
  logic [4:0] fflags_q;
  logic [4:0] ret_flags;

  assign ret_flags = retire_fire ? rsp_status_o : 5'b0;

  // A clear and a same-cycle retire leave only the retiring op's flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)             fflags_q <= 5'b0;
    else if (fflags_clr_i) fflags_q <= ret_flags;
    else                   fflags_q <= fflags_q | ret_flags;
  end

  assign fflags_o = fflags_q;
`else
  logic unused_fflags_clr;
  assign unused_fflags_clr = fflags_clr_i;
  assign fflags_o          = 5'b0;
`endif

endmodule

// File: tb/tb_fpnew_issue_rob.sv
// Scoreboard bench for fpnew_issue_rob: the bench plays core and FPU, a queue
// model of in-flight ops predicts every retire and handshake signal.

module tb_fpnew_issue_rob;

  localparam int WIDTH = 64;
  localparam int OP_W  = 32;
  localparam int DEPTH = 4;
  localparam int TAG_W = 2;

  logic clk = 1'b0;
  logic rst_i;
  logic req_valid_i, req_ready_o;
  logic [3*WIDTH-1:0] req_operands_i;
  logic [OP_W-1:0] req_op_i;
  logic fpu_in_valid_o, fpu_in_ready_i;
  logic [3*WIDTH-1:0] fpu_operands_o;
  logic [OP_W-1:0] fpu_op_o;
  logic [TAG_W-1:0] fpu_tag_o;
  logic fpu_out_valid_i, fpu_out_ready_o;
  logic [WIDTH-1:0] fpu_result_i;
  logic [4:0] fpu_status_i;
  logic [TAG_W-1:0] fpu_tag_i;
  logic fpu_flush_o;
  logic rsp_valid_o, rsp_ready_i;
  logic [WIDTH-1:0] rsp_result_o;
  logic [4:0] rsp_status_o;
  logic flush_i;
  logic [4:0] fflags_o;
  logic fflags_clr_i;
  logic [TAG_W:0] count_o;
  logic busy_o, protocol_err_o;

  always #5 clk = ~clk;

  fpnew_issue_rob #(.WIDTH(WIDTH), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_operands_i(req_operands_i), .req_op_i(req_op_i),
    .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
    .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o), .fpu_tag_o(fpu_tag_o),
    .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
    .fpu_flush_o(fpu_flush_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o),
    .flush_i(flush_i), .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
    .count_o(count_o), .busy_o(busy_o), .protocol_err_o(protocol_err_o)
  );

  int checks = 0;
  int errors = 0;
  int ret_cnt = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The FPU "computation" used by both the FPU stand-in and the scoreboard.
  function automatic logic [63:0] f_res(input logic [191:0] o);
    return o[63:0] + (o[127:64] ^ o[191:128]);
  endfunction

  typedef struct { logic [TAG_W-1:0] tag; logic [63:0] res; logic [4:0] st; bit done; } ent_t;
  typedef struct { logic [TAG_W-1:0] tag; logic [63:0] res; logic [4:0] st; } pend_t;

  ent_t  q[$];      // ops in program order, as the core sees them
  pend_t pend[$];   // ops inside the FPU stand-in awaiting a response
  int tail_m = 0;
  bit perr_m = 0;
  logic [4:0] ff_m = 5'b0;

  // FPU stand-in: capture every accepted issue from the DUT's FPU-side outputs.
  always @(negedge clk) begin
    if (!rst_i && fpu_in_valid_o && fpu_in_ready_i)
      pend.push_back('{fpu_tag_o, f_res(fpu_operands_o), fpu_op_o[4:0]});
  end

  // Monitor / scoreboard: compare this cycle, then advance the model to the next edge.
  always @(negedge clk) begin
    if (rst_i) begin
      q.delete(); tail_m = 0; perr_m = 0; ff_m = 5'b0;
    end else begin
      bit exp_iv, exp_rr, exp_rv, found;
      int fi;
      exp_iv = req_valid_i && (q.size() < DEPTH) && !flush_i;
      exp_rr = fpu_in_ready_i && (q.size() < DEPTH) && !flush_i;
      exp_rv = !flush_i && (q.size() > 0) && q[0].done;
      chk("in_valid", fpu_in_valid_o, exp_iv);
      chk("req_ready", req_ready_o, exp_rr);
      chk("fpu_flush", fpu_flush_o, flush_i);
      chk("out_ready", fpu_out_ready_o, !flush_i);
      chk("count", count_o, q.size());
      chk("busy", busy_o, q.size() != 0);
      chk("protocol_err", protocol_err_o, perr_m);
      chk("fflags", fflags_o, ff_m);
      if (exp_iv) begin
        chk("issue_tag", fpu_tag_o, tail_m);
        chk("issue_operands", fpu_operands_o, req_operands_i);
        chk("issue_op", fpu_op_o, req_op_i);
      end
      chk("rsp_valid", rsp_valid_o, exp_rv);
      if (exp_rv && rsp_valid_o) begin
        chk("rsp_result", rsp_result_o, q[0].res);
        chk("rsp_status", rsp_status_o, q[0].st);
      end
`ifdef FPNEW_ISSUE_ROB_FFLAGS_EN
      if (fflags_clr_i) ff_m = 5'b0;
`endif
      if (flush_i) begin
        q.delete(); tail_m = 0;
      end else begin
        if (fpu_out_valid_i) begin
          found = 0; fi = 0;
          for (int i = 0; i < q.size(); i++)
            if (q[i].tag == fpu_tag_i) begin found = 1; fi = i; end
          if (found && !q[fi].done) begin
            ent_t e;
            e = q[fi]; e.done = 1; q[fi] = e;
          end else perr_m = 1;
        end
        if (exp_rv && rsp_ready_i) begin
`ifdef FPNEW_ISSUE_ROB_FFLAGS_EN
          ff_m = ff_m | q[0].st;
`endif
          void'(q.pop_front());
          ret_cnt++;
        end
        if (exp_iv && fpu_in_ready_i) begin
          q.push_back('{tail_m[TAG_W-1:0], f_res(req_operands_i), req_op_i[4:0], 1'b0});
          tail_m = (tail_m + 1) % DEPTH;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
    req_valid_i = 0; fpu_out_valid_i = 0; flush_i = 0; fflags_clr_i = 0;
  endtask

  task automatic drive_req(input logic [4:0] st);
    req_valid_i = 1;
    req_operands_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    req_op_i = {$urandom, st};
    req_op_i[4:0] = st;
  endtask

  task automatic rsp_idx(input int idx);
    fpu_out_valid_i = 1;
    fpu_tag_i = pend[idx].tag;
    fpu_result_i = pend[idx].res;
    fpu_status_i = pend[idx].st;
    pend.delete(idx);
  endtask

  task automatic rsp_tag(input int t);
    int idx = -1;
    for (int i = 0; i < pend.size(); i++) if (pend[i].tag == t) idx = i;
    if (idx < 0) begin
      checks++; errors++;
      $display("FAIL rsp_tag: tag %0d not outstanding at FPU", t);
    end else rsp_idx(idx);
  endtask

  task automatic do_flush();
    flush_i = 1; pend.delete();
    #1 chk("flush_comb", fpu_flush_o, 1'b1);
    cyc();
  endtask

  task automatic drain();
    rsp_ready_i = 1;
    for (int i = 0; i < 100; i++) begin
      if (count_o == 0 && pend.size() == 0) break;
      if (pend.size() > 0) rsp_idx(0);
      cyc();
    end
    chk("drain_count", count_o, 0);
    rsp_ready_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst_i = 1; req_valid_i = 1; req_operands_i = '0; req_op_i = '0;
    fpu_in_ready_i = 1; fpu_out_valid_i = 0; fpu_result_i = '0; fpu_status_i = '0;
    fpu_tag_i = '0; rsp_ready_i = 0; flush_i = 0; fflags_clr_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_perr", protocol_err_o, 0);
    chk("rst_fflags", fflags_o, 0);
    chk("rst_in_valid", fpu_in_valid_o, 1);
    chk("rst_req_ready", req_ready_o, 1);
    req_valid_i = 0;
    rst_i = 0;
    cyc();

    // Reorder: tags 0,1,2 answered 2,0,1
    for (int i = 0; i < 3; i++) begin drive_req(5'($urandom)); cyc(); end
    rsp_tag(2); cyc();
    rsp_tag(0); cyc();
    rsp_tag(1); rsp_ready_i = 1; cyc();
    repeat (4) cyc();
    chk("reorder_retired", ret_cnt, 3);
    rsp_ready_i = 0;

    // Flush with 3 outstanding (one already answered)
    for (int i = 0; i < 3; i++) begin drive_req(5'($urandom)); cyc(); end
    rsp_tag(3); cyc();
    do_flush();
    chk("flush_count", count_o, 0);
    chk("flush_rsp_valid", rsp_valid_o, 0);

    // Full: next tags 0..3, then blocked
    for (int i = 0; i < 4; i++) begin drive_req(5'($urandom)); cyc(); end
    drive_req(5'($urandom));
    #1 chk("full_count", count_o, 4);
    chk("full_in_valid", fpu_in_valid_o, 0);
    chk("full_req_ready", req_ready_o, 0);
    rsp_tag(0); cyc();
    drive_req(5'($urandom)); rsp_ready_i = 1;
    #1 chk("full_retire_rsp_valid", rsp_valid_o, 1);
    chk("full_retire_blocks", fpu_in_valid_o, 0);
    cyc();
    rsp_ready_i = 0; drive_req(5'($urandom));
    #1 chk("full_resume_valid", fpu_in_valid_o, 1);
    chk("full_resume_tag", fpu_tag_o, 0);
    cyc();
    drain();

    // Stray response on an unallocated tag
    do_flush();
    drive_req(5'($urandom)); cyc();
    chk("stray_pre_perr", protocol_err_o, 0);
    fpu_out_valid_i = 1; fpu_tag_i = 3; fpu_result_i = {$urandom, $urandom}; fpu_status_i = 5'h1f;
    cyc();
    chk("stray_perr", protocol_err_o, 1);
    chk("stray_count", count_o, 1);
    repeat (3) cyc();
    chk("stray_perr_sticky", protocol_err_o, 1);
    drain();

    // Flags accumulate, then clear together with a retire
    drive_req(5'b00001); cyc();
    drive_req(5'b10000); rsp_idx(0); cyc();
    drive_req(5'b00100); rsp_idx(0); cyc();
    rsp_idx(0); cyc();
    cyc();
    rsp_ready_i = 1; cyc(); cyc(); rsp_ready_i = 0;
`ifdef FPNEW_ISSUE_ROB_FFLAGS_EN
    chk("fflags_accum", fflags_o, 5'b10001);
`else
    chk("fflags_off", fflags_o, 5'b00000);
`endif
    fflags_clr_i = 1; rsp_ready_i = 1; cyc(); rsp_ready_i = 0;
`ifdef FPNEW_ISSUE_ROB_FFLAGS_EN
    chk("fflags_clr_retire", fflags_o, 5'b00100);
`else
    chk("fflags_off_clr", fflags_o, 5'b00000);
`endif
    chk("flags_empty", count_o, 0);

    // Wrap: 10 ops streamed, each answered one cycle after issue
    do_flush();
    rsp_ready_i = 1;
    for (int i = 0; i < 10; i++) begin
      drive_req(5'($urandom));
      if (pend.size() > 0) rsp_idx(0);
      cyc();
    end
    if (pend.size() > 0) rsp_idx(0);
    cyc();
    repeat (3) cyc();
    chk("wrap_count", count_o, 0);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      fpu_in_ready_i = ($urandom % 4) != 0;
      rsp_ready_i = ($urandom % 3) != 0;
      fflags_clr_i = ($urandom % 20) == 0;
      if ($urandom % 60 == 0) begin
        flush_i = 1; pend.delete();
      end else begin
        if ($urandom % 2) drive_req(5'($urandom));
        if (pend.size() > 0 && ($urandom % 3) != 0) rsp_idx(int'($urandom % pend.size()));
      end
      cyc();
    end
    fpu_in_ready_i = 1;
    drain();
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpnew_issue_rob.md
# fpnew_issue_rob

In-order issue and reorder front-end that acts as the initiator for the FPU top-level valid/ready request/response interface. It accepts operations from the core, assigns each one a tag and issues it to the FPU. Because the FPU's output arbiter returns results from different operation groups out of order, the block collects them in a reorder buffer and retires them to the core strictly in program order. It sits between the core's FP decode stage and the FPU top.

## Interface
- WIDTH, 64: operand/result width; equals the FPU width.
- OP_W, 32: width of the opaque op bundle (op, op_mod, fmts, rnd_mode, vectorial), passed through unmodified.
- DEPTH, 4: ROB entries; power of two, >=2. TAG_W = $clog2(DEPTH), derived.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i / req_ready_o  in/out  1  core request handshake.
- req_operands_i  in  3*WIDTH  operands 0..2.
- req_op_i  in  OP_W  op bundle.
- fpu_in_valid_o / fpu_in_ready_i  out/in  1  FPU input handshake.
- fpu_operands_o  out  3*WIDTH; fpu_op_o  out  OP_W; fpu_tag_o  out  TAG_W  issued tag.
- fpu_out_valid_i / fpu_out_ready_o  in/out  1  FPU output handshake.
- fpu_result_i  in  WIDTH; fpu_status_i  in  5 (NV,DZ,OF,UF,NX); fpu_tag_i  in  TAG_W.
- fpu_flush_o  out  1  flush to FPU.
- rsp_valid_o / rsp_ready_i  out/in  1  retire handshake.
- rsp_result_o  out  WIDTH; rsp_status_o  out  5.
- flush_i  in  1  synchronous kill of all in-flight ops.
- fflags_o  out  5; fflags_clr_i  in  1  (see Configuration).
- count_o  out  TAG_W+1  occupancy; busy_o  out  1  = count_o != 0.
- protocol_err_o  out  1  sticky stray-response flag.

## Operation
- State: per-entry alloc and done bits, result[WIDTH], status[5]; head/tail pointers of TAG_W+1 bits (extra wrap bit). Empty: head==tail. Full: index bits equal, wrap bits differ.
- Issue: fpu_in_valid_o = req_valid_i & !full & !flush_i; req_ready_o = fpu_in_ready_i & !full & !flush_i. Operands and op are passed through combinationally; fpu_tag_o = tail[TAG_W-1:0]. On fpu_in_valid_o & fpu_in_ready_i: set alloc[tail], clear done[tail], tail++.
- fpu_in_valid_o never depends on fpu_in_ready_i, because the FPU's ready is combinationally a function of its valid.
- Full blocks issue even when a retire happens in the same cycle.
- Response: fpu_out_ready_o = !flush_i, held high otherwise; space is pre-allocated. On a handshake with alloc[tag] & !done[tag], write result and status and set done.
- A response to an entry that is unallocated or already done is dropped and sets protocol_err_o. protocol_err_o clears only on reset.
- Retire: rsp_valid_o = !empty & done[head] & !flush_i; rsp_result_o/rsp_status_o are read from entry head. On handshake: clear alloc[head], head++.
- Issue, response and retire may all occur in one cycle; each acts on its own entry.
- flush_i: fpu_flush_o = flush_i combinationally. Next edge: all alloc/done cleared, head=tail=0, count_o=0; the next issued tag is 0. Issue, response and retire are all suppressed in the flush cycle.

## Timing
- Reset (asynchronous, takes effect immediately): head=tail=0, alloc/done=0, fflags_o=0, protocol_err_o=0. While reset is held, rsp_valid_o=0, busy_o=0, count_o=0. fpu_in_valid_o follows req_valid_i; req_ready_o follows fpu_in_ready_i.
- Latency: no added cycles on the issue path. Minimum 1 cycle from the FPU response edge to rsp_valid_o: a result written at edge N is visible after edge N; there is no response-to-retire bypass.
- A retired entry becomes reusable for issue the cycle after its retire.
- count_o reflects registered pointers and changes only at clock edges.

## Configuration
- FPNEW_ISSUE_ROB_FFLAGS_EN defined:
  - fflags_o holds the sticky OR of rsp_status_o over every retire handshake.
  - fflags_clr_i zeroes it at the next edge; a retire in the same cycle as a clear contributes its flags after the clear.
- Not defined: no accumulator register; fflags_o is tied to 0 and fflags_clr_i is ignored.

## Test plan
- Reorder: DEPTH=4. Issue A,B,C (tags 0,1,2); respond on tags 2,0,1 on consecutive cycles. Required: retire order A,B,C with matching results; rsp_valid_o first high one cycle after the tag-0 response.
- Full: issue 4 ops with no responses. Required: count_o=4; fpu_in_valid_o=0 and req_ready_o=0 while req_valid_i=1. Then respond to tag 0 and retire it; issue resumes the following cycle with tag 0.
- Wrap: stream 10 ops, each responded 1 cycle after issue, with rsp_ready_i=1. Required: tags cycle 0,1,2,3,0,1,...; all 10 retire in order; count_o ends at 0.
- Flush: 3 ops outstanding, assert flush_i for 1 cycle. Required: fpu_flush_o=1 in that cycle; next cycle count_o=0, rsp_valid_o=0; next issue gets tag 0.
- Flags (macro on): retire ops with status 5'b00001 then 5'b10000. Required: fflags_o=5'b10001. Then assert fflags_clr_i together with a retire of status 5'b00100. Required: fflags_o=5'b00100.
- Stray response: only tag 0 outstanding; drive a response on tag 3. Required: it is ignored, protocol_err_o=1 and stays 1, count_o is unchanged.
